instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Owns the program counter and drives the word address of the instruction RAM, which reads combinationally.
- Registers each returned 32-bit instruction into a fetch/decode pipeline register and presents it downstream with a valid/ready handshake.
- Handles decode back-pressure, branch redirects (flush) and HALT detection.
- Sits directly upstream of the instruction RAM address port and directly downstream of its data output.

Parameters:
- ADDR_WIDTH, 10, width of PC and instruction RAM address.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset.
- HALT_OPCODE, 6'b111111, opcode field (instr[31:26]) that stops fetching.

Ports:
- clock  input  1  single rising-edge clock.
- reset  input  1  synchronous, active-low reset.
- startFetch  input  1  one-cycle pulse; leaves IDLE.
- ramAddress  output  ADDR_WIDTH  instruction RAM address; combinationally equal to pc.
- ramData  input  DATA_WIDTH  instruction RAM read data for ramAddress, same cycle.
- instrOut  output  DATA_WIDTH  registered instruction to decode.
- instrPc  output  ADDR_WIDTH  address instrOut was fetched from.
- instrValid  output  1  instrOut/instrPc hold a valid instruction.
- decodeReady  input  1  decode accepts instrOut this cycle.
- branchTaken  input  1  redirect request.
- branchTarget  input  ADDR_WIDTH  redirect address.
- halted  output  1  high in HALTED state.
- fetchCount  output  16  fetched-instruction counter (see Optional Feature).
- stallCount  output  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (reset==0 at a posedge): state=IDLE, pc=RESET_PC, instrOut=0, instrPc=0, instrValid=0, halted=0, counters=0. Reset overrides every other input.
- States: IDLE, RUN, HALTED.
  - IDLE -> RUN on startFetch. No fetch occurs in the startFetch cycle; the first capture happens in the next cycle.
  - RUN -> HALTED when the captured instruction has ramData[31:26]==HALT_OPCODE.
  - HALTED -> RUN only on branchTaken.
  - startFetch is ignored outside IDLE.
- Advance condition: adv = !instrValid || decodeReady.
- RUN, no branch, adv=1:
  - instrOut<=ramData, instrPc<=pc, instrValid<=1.
  - pc<=pc+1, modulo 2^ADDR_WIDTH, so 1023 wraps to 0.
- RUN, no branch, adv=0 (stall): pc, instrOut, instrPc and instrValid hold.
- Handshake: a transfer occurs on any posedge with instrValid && decodeReady. instrOut must not change while instrValid && !decodeReady.
- branchTaken (RUN or HALTED), highest priority after reset:
  - pc<=branchTarget, instrValid<=0 (flush), state<=RUN.
  - No capture that cycle, even if a stall is in progress.
  - Fetch from the target starts the next cycle, so redirect-to-valid latency is 2 cycles.
- HALT fetch:
  - The HALT word itself is delivered through instrOut/instrValid like any other instruction.
  - pc<=pc+1 still occurs.
  - Thereafter no further captures.
  - In HALTED, instrValid clears when the HALT word transfers and stays 0.
- branchTaken in IDLE is ignored.
- Simultaneous branchTaken and a transfer: the transfer completes, since decode consumed the word; then the register is flushed to invalid.
- halted = (state==HALTED), registered.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Defined:
  - fetchCount increments on every capture.
  - stallCount increments on every RUN cycle with instrValid && !decodeReady.
  - Both are 16-bit and saturate at 16'hFFFF.
  - Both clear on reset.
- Undefined: counter logic is not compiled; fetchCount and stallCount are constant 0.

Test Plan:
- Reset, then startFetch; RAM returns 32'h00A22000 at 0, 32'h08A21800 at 1; decodeReady=1 -> instrValid rises 2 cycles after startFetch with instrOut=32'h00A22000, instrPc=0; next cycle instrOut=32'h08A21800, instrPc=1; ramAddress=2.
- decodeReady=0 for 3 cycles while instrValid=1 at instrPc=1 -> instrOut, instrPc and ramAddress (2) are stable; with FETCH_PERF_COUNT_EN, stallCount=3.
- branchTaken with branchTarget=10'h3FF during a stall -> next cycle instrValid=0, ramAddress=10'h3FF; then instrPc=10'h3FF; then ramAddress wraps to 0.
- RAM word 32'hFC000000 at address 3 -> delivered with instrPc=3, halted=1 next cycle, ramAddress stays 4, instrValid=0 after transfer; branchTaken to 0 -> halted=0 and fetch resumes from 0.
- reset asserted mid-stall (instrValid=1, pc=5) -> next cycle every output is at its reset value, state IDLE; startFetch is required to resume.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction RAM port plus the fetch/decode handshake
// and the branch redirect request. The fetch unit is the master.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] ramAddress;
    logic [DATA_WIDTH-1:0] ramData;
    logic [DATA_WIDTH-1:0] instrOut;
    logic [ADDR_WIDTH-1:0] instrPc;
    logic                  instrValid;
    logic                  decodeReady;
    logic                  branchTaken;
    logic [ADDR_WIDTH-1:0] branchTarget;

    modport master (
        output ramAddress, instrOut, instrPc, instrValid,
        input  ramData, decodeReady, branchTaken, branchTarget
    );

    modport slave (
        input  ramAddress, instrOut, instrPc, instrValid,
        output ramData, decodeReady, branchTaken, branchTarget
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses a combinational-read
// instruction RAM, and registers each word into the fetch/decode register.
// Optional performance counters are compiled in with FETCH_PERF_COUNT_EN.
//
// state  | meaning
// IDLE   | waiting for startFetch, no fetching
// RUN    | fetching one word per advancing cycle
// HALTED | HALT word captured; only a branch restarts fetching
module instruction_fetch_unit #(
    parameter int                    ADDR_WIDTH  = 10,
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]            HALT_OPCODE = 6'b111111
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      startFetch,
    instruction_fetch_unit_if.master  bus,
    output logic                      halted,
    output logic [15:0]               fetchCount,
    output logic [15:0]               stallCount
);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] pc, pc_next;
    logic [DATA_WIDTH-1:0] instr_out, instr_out_next;
    logic [ADDR_WIDTH-1:0] instr_pc, instr_pc_next;
    logic                  instr_valid, instr_valid_next;
    logic                  capture;
    logic                  adv;

    assign bus.ramAddress = pc;
    assign bus.instrOut   = instr_out;
    assign bus.instrPc    = instr_pc;
    assign bus.instrValid = instr_valid;
    assign halted         = (state == HALTED);

    // Next-state logic: branch flush beats capture; stalls hold everything.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        instr_out_next   = instr_out;
        instr_pc_next    = instr_pc;
        instr_valid_next = instr_valid;
        capture          = 1'b0;
        adv              = !instr_valid || bus.decodeReady;
        case (state)
            IDLE: begin
                if (startFetch) state_next = RUN;
            end
            RUN: begin
                if (bus.branchTaken) begin
                    pc_next          = bus.branchTarget;
                    instr_valid_next = 1'b0;
                end else if (adv) begin
                    capture          = 1'b1;
                    instr_out_next   = bus.ramData;
                    instr_pc_next    = pc;
                    instr_valid_next = 1'b1;
                    pc_next          = pc + ADDR_WIDTH'(1);
                    if (bus.ramData[DATA_WIDTH-1 -: 6] == HALT_OPCODE) state_next = HALTED;
                end
            end
            HALTED: begin
                if (bus.branchTaken) begin
                    pc_next          = bus.branchTarget;
                    instr_valid_next = 1'b0;
                    state_next       = RUN;
                end else if (instr_valid && bus.decodeReady) begin
                    // HALT word consumed; nothing follows it
                    instr_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and pipeline register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_out   <= instr_out_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= instr_valid_next;
        end
    end

`ifdef FETCH_PERF_COUNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;

    // Saturating capture and RUN-stall counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (capture && fetch_cnt != 16'hFFFF) fetch_cnt <= fetch_cnt + 16'd1;
            if (state == RUN && instr_valid && !bus.decodeReady && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    assign fetchCount = fetch_cnt;
    assign stallCount = stall_cnt;
`else
    assign fetchCount = '0;
    assign stallCount = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: directed scenarios plus a randomized
// run scored against an in-order delivery model of the fetch stream.
module tb_instruction_fetch_unit;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef FETCH_PERF_COUNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          startFetch = 1'b0;
    logic          halted;
    logic [15:0]   fetchCount;
    logic [15:0]   stallCount;
    logic          decode_ready = 1'b0;
    logic          branch_taken = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [DW-1:0] ram [0:(1<<AW)-1];

    int n_checks = 0;
    int n_fail   = 0;
    logic [53:0] obs, req;

    instruction_fetch_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    assign bus.ramData      = ram[bus.ramAddress];
    assign bus.decodeReady  = decode_ready;
    assign bus.branchTaken  = branch_taken;
    assign bus.branchTarget = branch_target;

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .startFetch (startFetch),
        .bus        (bus),
        .halted     (halted),
        .fetchCount (fetchCount),
        .stallCount (stallCount)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // {valid, instrPc, instrOut, ramAddress, halted}
    function automatic logic [53:0] observe();
        return {bus.instrValid, bus.instrPc, bus.instrOut, bus.ramAddress, halted};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < (1<<AW); i++) ram[i] = 32'h0;
        ram[0] = 32'h00A22000; ram[1] = 32'h08A21800; ram[2] = 32'h20000002;
        ram[3] = 32'hFC000000; ram[4] = 32'h04000004; ram[10'h3FF] = 32'h12345678;
        reset = 1'b0; startFetch = 1'b1; branch_taken = 1'b1; branch_target = 10'h155; decode_ready = 1'b1;
        tick(); tick();
        obs = observe(); req = {1'b0, 10'd0, 32'd0, 10'd0, 1'b0};
        n_checks++; if (obs !== req || fetchCount !== 16'd0 || stallCount !== 16'd0) begin
            n_fail++; $display("FAIL reset_state: got %h fc=%0d sc=%0d required %h fc=0 sc=0", obs, fetchCount, stallCount, req);
        end
        reset = 1'b1; startFetch = 1'b0; branch_taken = 1'b0;
        tick();
        obs = observe(); req = {1'b0, 10'd0, 32'd0, 10'd0, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL idle_after_reset: got %h required %h", obs, req); end
        branch_taken = 1'b1; branch_target = 10'd5;
        tick();
        branch_taken = 1'b0;
        tick();
        obs = observe();
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL idle_ignores_branch: got %h required %h", obs, req); end
    endtask

    task automatic test_fetch_and_stall();
        startFetch = 1'b1; decode_ready = 1'b1;
        tick();
        startFetch = 1'b0;
        obs = observe(); req = {1'b0, 10'd0, 32'd0, 10'd0, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL no_fetch_in_start_cycle: got %h required %h", obs, req); end
        tick();
        obs = observe(); req = {1'b1, 10'd0, 32'h00A22000, 10'd1, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL first_fetch: got %h required %h", obs, req); end
        tick();
        obs = observe(); req = {1'b1, 10'd1, 32'h08A21800, 10'd2, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL second_fetch: got %h required %h", obs, req); end
        decode_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            startFetch = (i == 1);
            tick();
            obs = observe();
            n_checks++; if (obs !== req) begin n_fail++; $display("FAIL stall_hold_%0d: got %h required %h", i, obs, req); end
        end
        startFetch = 1'b0;
        n_checks++; if (stallCount !== 16'(PERF ? 3 : 0) || fetchCount !== 16'(PERF ? 2 : 0)) begin
            n_fail++; $display("FAIL counters_after_stall: got fc=%0d sc=%0d required fc=%0d sc=%0d", fetchCount, stallCount, PERF ? 2 : 0, PERF ? 3 : 0);
        end
    endtask

    task automatic test_branch_wrap();
        branch_taken = 1'b1; branch_target = 10'h3FF;
        tick();
        branch_taken = 1'b0; decode_ready = 1'b1;
        obs = observe(); req = {1'b0, 10'd1, 32'h08A21800, 10'h3FF, 1'b0};
        n_checks++; if (obs[53] !== 1'b0 || obs[10:0] !== req[10:0] || stallCount !== 16'(PERF ? 4 : 0)) begin
            n_fail++; $display("FAIL branch_flush: got %h sc=%0d required valid=0 addr=3ff sc=%0d", obs, stallCount, PERF ? 4 : 0);
        end
        tick();
        obs = observe(); req = {1'b1, 10'h3FF, 32'h12345678, 10'd0, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL branch_target_fetch_wrap: got %h required %h", obs, req); end
        tick();
        obs = observe(); req = {1'b1, 10'd0, 32'h00A22000, 10'd1, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL after_wrap: got %h required %h", obs, req); end
    endtask

    task automatic test_halt();
        tick(); tick();
        obs = observe(); req = {1'b1, 10'd2, 32'h20000002, 10'd3, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL pre_halt_fetch: got %h required %h", obs, req); end
        tick();
        obs = observe(); req = {1'b1, 10'd3, 32'hFC000000, 10'd4, 1'b1};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL halt_word_delivered: got %h required %h", obs, req); end
        decode_ready = 1'b0;
        tick();
        obs = observe();
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL halt_word_held: got %h required %h", obs, req); end
        decode_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = observe(); req = {1'b0, 10'd3, 32'hFC000000, 10'd4, 1'b1};
            n_checks++; if (obs !== req) begin n_fail++; $display("FAIL halted_idle_%0d: got %h required %h", i, obs, req); end
        end
        n_checks++; if (fetchCount !== 16'(PERF ? 7 : 0) || stallCount !== 16'(PERF ? 4 : 0)) begin
            n_fail++; $display("FAIL counters_halted: got fc=%0d sc=%0d required fc=%0d sc=%0d", fetchCount, stallCount, PERF ? 7 : 0, PERF ? 4 : 0);
        end
        branch_taken = 1'b1; branch_target = 10'd0;
        tick();
        branch_taken = 1'b0;
        obs = observe();
        n_checks++; if (obs[53] !== 1'b0 || obs[10:0] !== {10'd0, 1'b0}) begin
            n_fail++; $display("FAIL halt_restart: got valid=%b addr=%h halted=%b required valid=0 addr=000 halted=0", obs[53], obs[10:1], obs[0]);
        end
        tick();
        obs = observe(); req = {1'b1, 10'd0, 32'h00A22000, 10'd1, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL resume_fetch: got %h required %h", obs, req); end
    endtask

    task automatic test_reset_mid_stall();
        branch_taken = 1'b1; branch_target = 10'd4;
        tick();
        branch_taken = 1'b0;
        tick();
        decode_ready = 1'b0;
        tick();
        obs = observe(); req = {1'b1, 10'd4, 32'h04000004, 10'd5, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL stall_before_reset: got %h required %h", obs, req); end
        reset = 1'b0; startFetch = 1'b1; branch_taken = 1'b1; branch_target = 10'd9;
        tick();
        obs = observe(); req = {1'b0, 10'd0, 32'd0, 10'd0, 1'b0};
        n_checks++; if (obs !== req || fetchCount !== 16'd0 || stallCount !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_stall: got %h fc=%0d sc=%0d required %h fc=0 sc=0", obs, fetchCount, stallCount, req);
        end
        reset = 1'b1; startFetch = 1'b0; branch_taken = 1'b0; decode_ready = 1'b1;
        tick(); tick();
        obs = observe();
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL idle_needs_start: got %h required %h", obs, req); end
        startFetch = 1'b1;
        tick();
        startFetch = 1'b0;
        tick();
        obs = observe(); req = {1'b1, 10'd0, 32'h00A22000, 10'd1, 1'b0};
        n_checks++; if (obs !== req) begin n_fail++; $display("FAIL restart_fetch: got %h required %h", obs, req); end
    endtask

    // Delivery model: words reach decode in address order, one apart, and a
    // redirect makes the target the next word decode sees.
    task automatic test_random();
        logic [AW-1:0] exp_next, pre_pc, pre_addr, tgt, nxt_addr;
        logic [DW-1:0] pre_out, w;
        logic          pre_valid, rdy, br;
        int exp_fc, exp_sc, transfers;
        reset = 1'b0; branch_taken = 1'b0; decode_ready = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < (1<<AW); i++) begin
            w = $urandom;
            if (w[31:26] == 6'h3F) w[31] = 1'b0;
            ram[i] = w;
        end
        startFetch = 1'b1;
        tick();
        startFetch = 1'b0;
        exp_next = '0; exp_fc = 0; exp_sc = 0; transfers = 0;
        for (int c = 0; c < 2000; c++) begin
            decode_ready  = ($urandom_range(0, 9) < 7);
            branch_taken  = ($urandom_range(0, 19) == 0);
            branch_target = AW'($urandom);
            pre_valid = bus.instrValid; pre_pc = bus.instrPc; pre_out = bus.instrOut;
            pre_addr = bus.ramAddress; rdy = decode_ready; br = branch_taken; tgt = branch_target;
            if (pre_valid && rdy) begin
                n_checks++; if ({pre_pc, pre_out} !== {exp_next, ram[exp_next]}) begin
                    n_fail++; $display("FAIL rnd_transfer_order cyc %0d: got pc=%h instr=%h required pc=%h instr=%h", c, pre_pc, pre_out, exp_next, ram[exp_next]);
                end
                exp_next = pre_pc + 10'd1;
                transfers++;
            end
            if (pre_valid && !rdy) exp_sc++;
            if (!br && (!pre_valid || rdy)) exp_fc++;
            if (br) exp_next = tgt;
            tick();
            obs = observe();
            if (br) begin
                n_checks++; if (obs[53] !== 1'b0 || obs[10:0] !== {tgt, 1'b0}) begin
                    n_fail++; $display("FAIL rnd_branch cyc %0d: got %h required valid=0 addr=%h halted=0", c, obs, tgt);
                end
            end else if (pre_valid && !rdy) begin
                req = {1'b1, pre_pc, pre_out, pre_addr, 1'b0};
                n_checks++; if (obs !== req) begin n_fail++; $display("FAIL rnd_stall_hold cyc %0d: got %h required %h", c, obs, req); end
            end else begin
                nxt_addr = pre_addr + 10'd1;
                req = {1'b1, pre_addr, ram[pre_addr], nxt_addr, 1'b0};
                n_checks++; if (obs !== req) begin n_fail++; $display("FAIL rnd_capture cyc %0d: got %h required %h", c, obs, req); end
            end
        end
        branch_taken = 1'b0;
        n_checks++; if (fetchCount !== 16'(PERF ? exp_fc : 0) || stallCount !== 16'(PERF ? exp_sc : 0)) begin
            n_fail++; $display("FAIL rnd_counters: got fc=%0d sc=%0d required fc=%0d sc=%0d", fetchCount, stallCount, PERF ? exp_fc : 0, PERF ? exp_sc : 0);
        end
        n_checks++; if (transfers < 500) begin
            n_fail++; $display("FAIL rnd_throughput: got %0d transfers required at least 500", transfers);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_fetch_and_stall();
        test_branch_wrap();
        test_halt();
        test_reset_mid_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
